ring_buf: RTL and testbench

- Replaying buffer between a show-ahead subkey FIFO (gen_subkey output) and the key-search compare loop.
- Pulls up to DEPTH words from the upstream FIFO, then stops pulling.
- Replays the captured batch cyclically on demand, flagging the last entry of each pass.
- The owner resets it (active-low reset) to load the next batch; the upstream FIFO is not reset and continues from where it left off.

---
 rtl/ring_buf_if.sv | 31 +++
 rtl/ring_buf_mem.sv | 44 ++++
 rtl/ring_buf.sv | 93 +++++++++
 tb/tb_ring_buf.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : ring_buf_if
// Description : Upstream show-ahead FIFO port plus replay port of ring_buf.
//               slave = ring_buf side, master = the block driving it.
// Revision    : 1.0 - initial release
// ============================================================================
interface ring_buf_if #(
    parameter int WIDTH = 24
);
    logic [WIDTH-1:0] FIFO_RDDATA;
    logic             FIFO_RDEN;
    logic             FIFO_RDEMPTY;
    logic             FIFO_DONE;
    logic             RDEN;
    logic [WIDTH-1:0] RDDATA;
    logic             FULL;
    logic             DONE;
    logic             END;

    modport slave (
        input  FIFO_RDDATA, FIFO_RDEMPTY, FIFO_DONE, RDEN,
        output FIFO_RDEN, RDDATA, FULL, DONE, END
    );

    modport master (
        output FIFO_RDDATA, FIFO_RDEMPTY, FIFO_DONE, RDEN,
        input  FIFO_RDEN, RDDATA, FULL, DONE, END
    );
endinterface
`default_nettype wire

// File: rtl/ring_buf_mem.sv
`default_nettype none
// ============================================================================
// Module      : ring_buf_mem
// Description : DEPTH x WIDTH register-file RAM, one write port and one
//               registered read port. Array contents survive reset; only the
//               read register clears.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_buf_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 24,
    parameter int AW    = 4
) (
    input  wire logic             CLK,
    input  wire logic             RESETn,
    input  wire logic             i_we,
    input  wire logic [AW-1:0]    i_waddr,
    input  wire logic [WIDTH-1:0] i_wdata,
    input  wire logic             i_re,
    input  wire logic [AW-1:0]    i_raddr,
    output logic      [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Storage array: written on each capture, never cleared.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register: loads only on a replay read, otherwise holds.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/ring_buf.sv
`default_nettype none
// ============================================================================
// Module      : ring_buf
// Description : Captures up to DEPTH words from a show-ahead FIFO, then
//               replays the batch cyclically on RDEN, flagging the last entry.
//               A reset abandons the batch so the next one can be loaded.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_buf #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 24
) (
    input  wire logic CLK,
    input  wire logic RESETn,
    ring_buf_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_full;
    logic          r_done;
    logic          r_end;

    logic             w_pop;
    logic             w_up_end;
    logic             w_rd;
    logic             w_last;
    logic [WIDTH-1:0] w_rddata;

    // Pop only while filling and there is still room in the batch.
    assign w_pop    = ~r_full & ~bus.FIFO_RDEMPTY & (r_count < CW'(DEPTH));
    // Upstream has nothing more to give, now or ever.
    assign w_up_end = bus.FIFO_DONE & bus.FIFO_RDEMPTY;
    // Replay reads are ignored until the batch is captured.
    assign w_rd     = bus.RDEN & r_full;
    // Wrap at the actual batch size N, not at a power of two.
    assign w_last   = ({1'b0, r_rd_ptr} == (r_count - CW'(1)));

    // Fill counter, pointers and status flags.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_done   <= 1'b0;
            r_end    <= 1'b0;
        end else begin
            if (w_pop) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                r_count  <= r_count + CW'(1);
            end
            // Batch closes on the DEPTH-th pop or when upstream runs dry
            // with a non-empty partial batch.
            if (!r_full && ((w_pop && (r_count == CW'(DEPTH - 1))) ||
                            (w_up_end && (r_count != '0)))) begin
                r_full <= 1'b1;
            end
            if (w_up_end) begin
                r_done <= 1'b1;
            end
            if (w_rd) begin
                r_end    <= w_last;
                r_rd_ptr <= w_last ? '0 : r_rd_ptr + PW'(1);
            end
        end
    end

    ring_buf_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (PW)
    ) u_mem (
        .CLK     (CLK),
        .RESETn  (RESETn),
        .i_we    (w_pop),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.FIFO_RDDATA),
        .i_re    (w_rd),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rddata)
    );

    assign bus.FIFO_RDEN = w_pop;
    assign bus.RDDATA    = w_rddata;
    assign bus.FULL      = r_full;
    assign bus.DONE      = r_done;
    assign bus.END       = r_end;
endmodule
`default_nettype wire

// File: tb/tb_ring_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_buf
// Description : Self-checking bench for ring_buf with a show-ahead upstream
//               FIFO model and a batch/replay reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_buf;
    localparam int DEPTH = 4;
    localparam int WIDTH = 24;

    logic CLK = 1'b0;
    logic RESETn;
    always #5 CLK = ~CLK;

    ring_buf_if #(.WIDTH(WIDTH)) bus ();

    ring_buf #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Upstream FIFO model
    logic [WIDTH-1:0] up_q[$];
    bit               up_done;
    bit               stall;

    // Batch / replay model
    logic [WIDTH-1:0] batch[$];
    bit               m_full;
    int               rp_idx;
    logic [WIDTH-1:0] exp_data;
    bit               exp_end;

    // Values sampled just before each rising edge
    bit s_pop;
    bit s_rd;

    task automatic drive_up();
        bus.FIFO_RDEMPTY = (up_q.size() == 0) || stall;
        bus.FIFO_DONE    = up_done;
        bus.FIFO_RDDATA  = (up_q.size() > 0) ? up_q[0] : 24'hDEAD00;
    endtask

    // One clock: sample handshakes at negedge, apply the upstream pop after
    // the edge, leave outputs settled for checking.
    task automatic tick();
        logic [WIDTH-1:0] tmp;
        @(negedge CLK);
        s_pop = bus.FIFO_RDEN;
        s_rd  = bus.RDEN;
        @(posedge CLK);
        #1;
        if (s_pop && up_q.size() > 0) tmp = up_q.pop_front();
        cyc++;
        drive_up();
        #1;
    endtask

    // Reset pulse that stays clear of any rising edge.
    task automatic do_reset();
        RESETn = 1'b0;
        #2;
        RESETn = 1'b1;
        m_full   = 1'b0;
        rp_idx   = 0;
        exp_data = '0;
        exp_end  = 1'b0;
    endtask

    // Capture phase: expected batch is the first N words the upstream offers.
    task automatic fill(input bit rand_stall, input bit rand_rden);
        int n_exp, pops, last_pop, size0, t;
        bit exp_done;
        size0 = up_q.size();
        n_exp = up_done ? ((size0 < DEPTH) ? size0 : DEPTH) : DEPTH;
        batch.delete();
        for (int i = 0; i < n_exp; i++) batch.push_back(up_q[i]);
        pops = 0; last_pop = -10; t = 0;
        while (!(m_full || (n_exp == 0 && t >= 5)) && t < 60) begin
            stall    = (rand_stall && !up_done) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.RDEN = rand_rden ? 1'($urandom_range(0, 1)) : 1'b0;
            drive_up();
            tick();
            t++;
            if (s_pop) begin pops++; last_pop = cyc; end
            if (n_exp > 0 && pops == n_exp && (n_exp == DEPTH || cyc > last_pop))
                m_full = 1'b1;
            n_cmp++;
            if (bus.FULL !== m_full) begin
                n_bad++;
                $display("FAIL fill_full cyc=%0d got=%b exp=%b pops=%0d", cyc, bus.FULL, m_full, pops);
            end
            n_cmp++;
            if (bus.RDDATA !== '0 || bus.END !== 1'b0) begin
                n_bad++;
                $display("FAIL fill_rd_ignored cyc=%0d rddata=%h end=%b exp 0/0", cyc, bus.RDDATA, bus.END);
            end
        end
        if (n_exp > 0 && !m_full) begin
            n_bad++; n_cmp++;
            $display("FAIL fill_timeout pops=%0d exp=%0d", pops, n_exp);
        end
        stall = 1'b0; bus.RDEN = 1'b0; drive_up();
        tick();
        exp_done = up_done && (up_q.size() == 0);
        n_cmp++;
        if (pops !== n_exp) begin
            n_bad++; $display("FAIL fill_pops got=%0d exp=%0d", pops, n_exp);
        end
        n_cmp++;
        if (up_q.size() !== size0 - n_exp) begin
            n_bad++; $display("FAIL fill_up_left got=%0d exp=%0d", up_q.size(), size0 - n_exp);
        end
        n_cmp++;
        if (bus.FIFO_RDEN !== 1'b0) begin
            n_bad++; $display("FAIL fill_rden_after got=%b exp=0", bus.FIFO_RDEN);
        end
        n_cmp++;
        if (bus.DONE !== exp_done) begin
            n_bad++; $display("FAIL fill_done got=%b exp=%b", bus.DONE, exp_done);
        end
        n_cmp++;
        if (bus.FULL !== (n_exp > 0)) begin
            n_bad++; $display("FAIL fill_full_final got=%b exp=%b", bus.FULL, (n_exp > 0));
        end
        n_cmp++;
        if (bus.RDDATA !== '0) begin
            n_bad++; $display("FAIL fill_rddata_zero got=%h exp=0", bus.RDDATA);
        end
    endtask

    // Replay phase: expected word is batch[index mod N], END on the last.
    task automatic replay(input int ncyc, input int nfixed);
        for (int i = 0; i < ncyc; i++) begin
            bus.RDEN = (i < nfixed) ? 1'b1 : ((nfixed == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
            tick();
            if (s_rd && m_full) begin
                exp_data = batch[rp_idx];
                exp_end  = (rp_idx == batch.size() - 1);
                rp_idx   = (rp_idx + 1) % batch.size();
            end
            n_cmp++;
            if (bus.RDDATA !== exp_data || bus.END !== exp_end) begin
                n_bad++;
                $display("FAIL replay cyc=%0d rddata=%h end=%b exp %h/%b", cyc, bus.RDDATA, bus.END, exp_data, exp_end);
            end
        end
        bus.RDEN = 1'b0;
    endtask

    task automatic test_reset();
        up_q.delete(); up_done = 0; stall = 0; bus.RDEN = 1'b0; drive_up();
        RESETn = 1'b1;
        #2;
        RESETn = 1'b0;
        #1;
        n_cmp++;
        if (bus.FULL !== 1'b0 || bus.DONE !== 1'b0 || bus.END !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags full=%b done=%b end=%b exp 0", bus.FULL, bus.DONE, bus.END);
        end
        n_cmp++;
        if (bus.RDDATA !== '0) begin
            n_bad++; $display("FAIL reset_rddata got=%h exp=0", bus.RDDATA);
        end
        RESETn = 1'b1;
        m_full = 0; rp_idx = 0; exp_data = '0; exp_end = 0;
        for (int i = 0; i < 3; i++) begin
            bus.RDEN = 1'($urandom_range(0, 1));
            tick();
            n_cmp++;
            if (bus.FIFO_RDEN !== 1'b0 || bus.FULL !== 1'b0 || bus.RDDATA !== '0) begin
                n_bad++; $display("FAIL reset_idle rden=%b full=%b rddata=%h exp 0", bus.FIFO_RDEN, bus.FULL, bus.RDDATA);
            end
        end
    endtask

    task automatic test_full_batch();
        do_reset();
        up_q.delete(); up_done = 0;
        for (int i = 1; i <= 6; i++) up_q.push_back(WIDTH'(i));
        drive_up();
        fill(1'b0, 1'b0);
        n_cmp++;
        if (up_q[0] !== 24'h000005) begin
            n_bad++; $display("FAIL full_head got=%h exp=000005", up_q[0]);
        end
        replay(11, 9);
    endtask

    task automatic test_reset_mid_replay();
        replay(2, 1);
        do_reset();
        up_done = 1'b1; drive_up();
        fill(1'b0, 1'b1);
        replay(8, 0);
    endtask

    task automatic test_partial();
        do_reset();
        up_q.delete(); up_q.push_back(24'h00000A); up_q.push_back(24'h00000B);
        up_done = 1'b1; drive_up();
        fill(1'b0, 1'b0);
        replay(4, 4);
    endtask

    task automatic test_single();
        do_reset();
        up_q.delete(); up_q.push_back(24'h00ABCD); up_done = 1'b1; drive_up();
        fill(1'b0, 1'b0);
        replay(4, 3);
    endtask

    task automatic test_stall_fill();
        do_reset();
        up_q.delete(); up_done = 0;
        for (int i = 0; i < 6; i++) up_q.push_back(WIDTH'($urandom));
        drive_up();
        fill(1'b1, 1'b1);
        replay(12, 0);
    endtask

    task automatic test_random_batches();
        int sz;
        for (int k = 0; k < 8; k++) begin
            do_reset();
            up_q.delete();
            sz = (k == 0) ? 0 : $urandom_range(0, 7);
            for (int i = 0; i < sz; i++) up_q.push_back(WIDTH'($urandom));
            up_done = (sz < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
            drive_up();
            fill(1'b1, 1'b1);
            if (m_full) replay(10, 0);
        end
    endtask

    initial begin
        bus.RDEN = 1'b0;
        RESETn   = 1'b1;
        stall    = 1'b0;
        up_done  = 1'b0;
        drive_up();
        test_reset();
        test_full_batch();
        test_reset_mid_replay();
        test_partial();
        test_single();
        test_stall_fill();
        test_random_batches();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
